// File: rtl/reg_bus_initiator.sv
// Register bus initiator.
// Turns a command handshake plus byte streams into one multi-byte register
// bus access. Bytes go out in ascending reg_bytecnt order. All bus and
// stream outputs are registered except wr_ready.
module reg_bus_initiator #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_i,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic                                 cmd_write,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] cmd_address,
  input  logic [pBYTECNT_SIZE-1:0]             cmd_len,
  input  logic [7:0]                           wr_data,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  output logic [7:0]                           rd_data,
  output logic                                 rd_valid,
  input  logic                                 rd_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           write_data,
  input  logic [7:0]                           read_data,
  output logic                                 reg_read,
  output logic                                 reg_write,
  output logic                                 reg_addrvalid
);

  typedef enum logic [2:0] {
    IDLE, SETUP, WR_WAIT, WR_STB, RD1, RD2, RD_OUT, DONE
  } state_t;

  state_t                   state, state_n;
  logic [pBYTECNT_SIZE-1:0] idx, idx_n;
  logic [pBYTECNT_SIZE-1:0] len_q;
  logic                     write_q;
  logic                     accept;
  logic                     last_byte;

  // A command is taken only when the registered ready is seen in IDLE.
  assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
  assign last_byte = (idx == len_q);

  // Write bytes are only pulled while waiting for one; elsewhere they stay put.
  assign wr_ready  = (state == WR_WAIT) && wr_valid;

  // The byte index doubles as the bus byte count; it is stable across strobes.
  assign reg_bytecnt = idx;

  // Next-state and byte-index sequencing.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SETUP;
          idx_n   = '0;
        end
      end
      SETUP:   state_n = write_q ? WR_WAIT : RD1;
      WR_WAIT: if (wr_valid) state_n = WR_STB;
      WR_STB: begin
        if (last_byte) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = WR_WAIT;
        end
      end
      RD1:     state_n = RD2;
      RD2:     state_n = RD_OUT;
      RD_OUT: begin
        if (rd_ready) begin
          if (last_byte) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = RD1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and registered control outputs, decoded from the next state.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      idx           <= '0;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
      rd_valid      <= 1'b0;
      reg_addrvalid <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      cmd_ready     <= (state_n == IDLE);
      busy          <= (state_n != IDLE);
      done          <= (state_n == DONE);
      reg_read      <= (state_n == RD1) || (state_n == RD2);
      reg_write     <= (state_n == WR_STB);
      rd_valid      <= (state_n == RD_OUT);
      reg_addrvalid <= (state_n != IDLE) && (state_n != DONE);
    end
  end

  // Bus address and data bytes; cleared on reset so an abort leaves the bus quiet.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      reg_address <= '0;
      write_data  <= '0;
      rd_data     <= '0;
    end else begin
      if (accept)
        reg_address <= cmd_address;
      if ((state == WR_WAIT) && wr_valid)
        write_data <= wr_data;
      // Sampling at the end of the second strobe cycle suits both
      // combinational and one-cycle-late responders.
      if (state == RD2)
        rd_data <= read_data;
    end
  end

  // Command direction and length are only consulted after an accept.
  always_ff @(posedge usb_clk) begin
    if (accept) begin
      write_q <= cmd_write;
      len_q   <= cmd_len;
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Testbench for reg_bus_initiator: table of whole commands with hand-computed
// results, per-cycle protocol checks, plus a reset-mid-read sequence.
module tb_reg_bus_initiator;

  logic        usb_clk;
  logic        reset_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [13:0] cmd_address;
  logic [6:0]  cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        done;
  logic [13:0] reg_address;
  logic [6:0]  reg_bytecnt;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;

  int checks;
  int errors;

  reg_bus_initiator #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) dut (
    .usb_clk(usb_clk), .reset_i(reset_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .write_data(write_data), .read_data(read_data),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  // Responder contents: "ArmTrace" in bytes 0..7, index ^ 0x5A above.
  function automatic logic [7:0] rmodel(input int i);
    case (i)
      0: return 8'h41;
      1: return 8'h72;
      2: return 8'h6d;
      3: return 8'h54;
      4: return 8'h72;
      5: return 8'h61;
      6: return 8'h63;
      7: return 8'h65;
      default: return 8'(i) ^ 8'h5A;
    endcase
  endfunction

  assign read_data = reg_read ? rmodel(int'(reg_bytecnt)) : 8'h00;

  typedef struct {
    logic        w;
    logic [13:0] addr;
    logic [6:0]  len;
    logic [7:0]  base;
    int          gap;
    int          stall;
    logic        hold;
    int          exp_n;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one command from a post-edge point to its done pulse.
  task automatic run_cmd(input vec_t v, output int nstb, output logic [7:0] last,
                         output int ndone, output int nrdcyc, output int hs_cyc,
                         output int done_cyc);
    int   cyc, k, nrd, stall_left, last_stb;
    logic acc, cons, hs;
    cyc = 0; k = 0; nrd = 0; nstb = 0; ndone = 0; nrdcyc = 0;
    hs_cyc = -1; done_cyc = -1; last = 8'h00; last_stb = -10;
    stall_left = v.stall;
    cmd_write = v.w; cmd_address = v.addr; cmd_len = v.len; cmd_valid = 1'b1;
    while (ndone == 0 && cyc < 3000) begin
      wr_valid = v.w && (v.gap == 0 || (cyc % v.gap) == 0);
      wr_data  = v.base + 8'(k * 17);
      rd_ready = rd_valid && (stall_left == 0);
      #1;
      acc  = cmd_valid && cmd_ready;
      cons = wr_valid && wr_ready;
      hs   = rd_valid && rd_ready;
      chk("wr_ready_implies_wr_valid", 32'(wr_ready && !wr_valid), 32'd0);
      if (rd_valid) begin
        chk("rd_data", 32'(rd_data), 32'(rmodel(nrd)));
        chk("no_reg_read_while_rd_valid", 32'(reg_read), 32'd0);
      end
      if (hs) begin
        last = rd_data; nrd++; hs_cyc = cyc;
      end else if (rd_valid && stall_left > 0) begin
        stall_left--;
      end
      @(posedge usb_clk); #1; cyc++;
      if (acc && !v.hold) cmd_valid = 1'b0;
      if (cons) k++;
      chk("read_write_exclusive", 32'(reg_read && reg_write), 32'd0);
      chk("cmd_ready_low_while_busy", 32'(busy && cmd_ready), 32'd0);
      if (reg_write) begin
        chk("wr_bytecnt", 32'(reg_bytecnt), 32'(nstb));
        chk("write_data", 32'(write_data), 32'(v.base + 8'(nstb * 17)));
        chk("strobe_after_capture", 32'(k), 32'(nstb + 1));
        chk("wr_strobe_spacing", 32'(cyc - last_stb >= 2), 32'd1);
        chk("wr_addrvalid", 32'(reg_addrvalid), 32'd1);
        chk("wr_address", 32'(reg_address), 32'(v.addr));
        last = write_data; last_stb = cyc; nstb++;
      end
      if (reg_read) begin
        nrdcyc++;
        chk("rd_bytecnt", 32'(reg_bytecnt), 32'(nrd));
        chk("rd_addrvalid", 32'(reg_addrvalid), 32'd1);
        chk("rd_address", 32'(reg_address), 32'(v.addr));
      end
      if (done) begin
        ndone++; done_cyc = cyc; cmd_valid = 1'b0;
        chk("addrvalid_low_at_done", 32'(reg_addrvalid), 32'd0);
      end
    end
    if (!v.w) nstb = nrd;
    wr_valid = 1'b0; rd_ready = 1'b0; cmd_valid = 1'b0;
    if (ndone == 0) chk("cmd_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int         nstb, ndone, nrdcyc, hs_cyc, done_cyc, nr, cyc;
    logic [7:0] last;
    logic       acc;
    checks = 0; errors = 0;

    vecs[0] = '{1'b1, 14'h0005, 7'd7,   8'h11, 0, 0,  1'b0, 8,   8'h88};
    vecs[1] = '{1'b0, 14'h0000, 7'd7,   8'h00, 0, 0,  1'b0, 8,   8'h65};
    vecs[2] = '{1'b0, 14'h1234, 7'd0,   8'h00, 0, 20, 1'b0, 1,   8'h41};
    vecs[3] = '{1'b1, 14'h3FFF, 7'd2,   8'h30, 5, 0,  1'b1, 3,   8'h52};
    vecs[4] = '{1'b1, 14'h2AAA, 7'd0,   8'hA5, 0, 0,  1'b0, 1,   8'hA5};
    vecs[5] = '{1'b1, 14'h0100, 7'd127, 8'h00, 0, 0,  1'b0, 128, 8'h6F};
    vecs[6] = '{1'b0, 14'h0FFF, 7'd127, 8'h00, 0, 0,  1'b0, 128, 8'h25};

    reset_i = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_len = '0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge usb_clk);
    #1;
    chk("reset_ctrl", 32'({cmd_ready, busy, done, reg_read, reg_write,
                           reg_addrvalid, rd_valid, wr_ready}), 32'd0);
    chk("reset_address", 32'(reg_address), 32'd0);
    chk("reset_bytecnt", 32'(reg_bytecnt), 32'd0);
    chk("reset_data", 32'({write_data, rd_data}), 32'd0);
    reset_i = 1'b0;
    @(posedge usb_clk); #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i], nstb, last, ndone, nrdcyc, hs_cyc, done_cyc);
      chk("byte_count", 32'(nstb), 32'(vecs[i].exp_n));
      chk("last_byte", 32'(last), 32'(vecs[i].exp_last));
      chk("done_pulses", 32'(ndone), 32'd1);
      if (!vecs[i].w) begin
        chk("reg_read_cycles", 32'(nrdcyc), 32'(2 * (int'(vecs[i].len) + 1)));
        chk("done_after_rd_handshake", 32'(done_cyc), 32'(hs_cyc + 1));
      end else begin
        chk("no_reg_read_on_write", 32'(nrdcyc), 32'd0);
      end
      @(posedge usb_clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("ready_after_done", 32'(cmd_ready), 32'd1);
      chk("not_busy_after_done", 32'(busy), 32'd0);
    end

    // Abort a read during the second strobe cycle of byte 1.
    cmd_write = 1'b0; cmd_address = 14'h0ABC; cmd_len = 7'd7;
    cmd_valid = 1'b1; rd_ready = 1'b1; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 50) begin
      #1;
      acc = cmd_valid && cmd_ready;
      @(posedge usb_clk); #1; cyc++;
      if (acc) cmd_valid = 1'b0;
      if (reg_read) nr++;
    end
    chk("reached_rd2_byte1", 32'(nr), 32'd4);
    chk("rd2_byte1_bytecnt", 32'(reg_bytecnt), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("abort_ctrl", 32'({cmd_ready, busy, done, reg_read, reg_write,
                           reg_addrvalid, rd_valid, wr_ready}), 32'd0);
    chk("abort_address", 32'(reg_address), 32'd0);
    chk("abort_bytecnt", 32'(reg_bytecnt), 32'd0);
    chk("abort_data", 32'({write_data, rd_data}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge usb_clk); #1;
      chk("abort_no_done", 32'({done, reg_read, reg_write}), 32'd0);
    end
    reset_i = 1'b0; rd_ready = 1'b0;
    @(posedge usb_clk); #1;
    chk("ready_after_abort", 32'(cmd_ready), 32'd1);
    run_cmd(vecs[1], nstb, last, ndone, nrdcyc, hs_cyc, done_cyc);
    chk("post_abort_bytes", 32'(nstb), 32'd8);
    chk("post_abort_last", 32'(last), 32'h65);
    chk("post_abort_done", 32'(ndone), 32'd1);
    chk("post_abort_read_cycles", 32'(nrdcyc), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
